// File: rtl/alu_exec.sv
// alu_exec: executes 8XYN register-register ALU instructions against a
// 16 x 8 register file (V0..VF). Operands are latched on accept, the external
// ALU result is captured one cycle later, then written back to VX and
// optionally VF (flag last, so VF ends holding the flag when X=F).
module alu_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_out,
  input  logic        alu_vf_wr,
  input  logic        alu_flag,
  input  logic        ext_we,
  input  logic [3:0]  ext_addr,
  input  logic [7:0]  ext_wdata,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, WB_VX, WB_VF} state_t;

  state_t      state_q, state_d;
  logic [7:0]  regs_q [16];
  logic [3:0]  x_q;
  logic [7:0]  a_q, b_q;
  logic [3:0]  op_q;
  logic [7:0]  res_q;
  logic        flag_q, vf_wr_q;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        load_ops;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        legal;

  // Only 8XYN with N in {0..7, E} is executed.
  assign legal = (instr[15:12] == 4'h8) && ((instr[3] == 1'b0) || (instr[3:0] == 4'hE));

  assign instr_ready = (state_q == IDLE);
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rd_data     = regs_q[rd_addr];
  assign done        = done_q;
  assign illegal     = illegal_q;

  // Next state, the single register-file write port, and pulse requests.
  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    wr_addr   = 4'h0;
    wr_data   = 8'h00;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    load_ops  = 1'b0;
    case (state_q)
      IDLE: begin
        // External loads are only honoured while no instruction is in flight.
        if (ext_we) begin
          wr_en   = 1'b1;
          wr_addr = ext_addr;
          wr_data = ext_wdata;
        end
        if (instr_valid) begin
          if (legal) begin
            load_ops = 1'b1;
            state_d  = EXEC;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        state_d = WB_VX;
      end
      WB_VX: begin
        wr_en   = 1'b1;
        wr_addr = x_q;
        wr_data = res_q;
        if (vf_wr_q) begin
          state_d = WB_VF;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WB_VF: begin
        wr_en   = 1'b1;
        wr_addr = 4'hF;
        wr_data = {7'b0, flag_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, operand latches and captured ALU result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      x_q       <= 4'h0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      op_q      <= 4'h0;
      res_q     <= 8'h00;
      flag_q    <= 1'b0;
      vf_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (load_ops) begin
        // Register reads here see pre-edge contents, even if ext_we writes now.
        x_q  <= instr[11:8];
        a_q  <= regs_q[instr[11:8]];
        b_q  <= regs_q[instr[7:4]];
        op_q <= instr[3:0];
      end
      if (state_q == EXEC) begin
        res_q   <= alu_out;
        flag_q  <= alu_flag;
        vf_wr_q <= alu_vf_wr;
      end
    end
  end

  // Register file: cleared on reset, one write per cycle otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
`timescale 1ns/1ps
// Testbench for alu_exec: the bench plays the external ALU, keeps an
// architectural model of V0..VF, and checks every done/illegal pulse against
// a queue of expected outcomes (pulse kind, cycle, full register file).
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_out;
  logic        alu_vf_wr, alu_flag;
  logic        ext_we;
  logic [3:0]  ext_addr;
  logic [7:0]  ext_wdata;
  logic [3:0]  rd_addr = 4'h0;
  logic [7:0]  rd_data;
  logic        done, illegal;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Bench-side ALU with an optional forced result.
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_out = 8'h00;
  logic       ovr_flag = 1'b0;
  logic       ovr_vf = 1'b0;

  typedef struct packed {
    bit           is_done;
    int           cyc;
    logic [127:0] regs;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] m [16];

  alu_exec dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_vf_wr(alu_vf_wr), .alu_flag(alu_flag), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
    .illegal(illegal)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CHIP-8 8XYN semantics: returns {vf_wr, flag, result}.
  function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      4'h0: return {2'b00, b};
      4'h1: return {2'b00, a | b};
      4'h2: return {2'b00, a & b};
      4'h3: return {2'b00, a ^ b};
      4'h4: begin s = {1'b0, a} + {1'b0, b}; return {1'b1, s[8], s[7:0]}; end
      4'h5: return {1'b1, (a >= b), 8'(a - b)};
      4'h6: return {1'b1, a[0], 8'(a >> 1)};
      4'h7: return {1'b1, (b >= a), 8'(b - a)};
      4'hE: return {1'b1, a[7], 8'(a << 1)};
      default: return 10'h000;
    endcase
  endfunction

  assign {alu_vf_wr, alu_flag, alu_out} = ovr_en ? {ovr_vf, ovr_flag, ovr_out} : alu_ref(alu_op, alu_a, alu_b);

  function automatic logic [127:0] snap();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = m[i];
    return r;
  endfunction

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic ext_write(input logic [3:0] a, input logic [7:0] d);
    ext_we = 1'b1; ext_addr = a; ext_wdata = d;
    @(posedge clk); #1;
    ext_we = 1'b0;
    m[a] = d;
  endtask

  // Issue one instruction (optionally with a coincident external write) and
  // push the expected outcome. Returns with the DUT back in IDLE.
  task automatic do_instr(input logic [15:0] ins, input bit ext, input logic [3:0] ea,
                          input logic [7:0] ed, input bit junk);
    logic [3:0] x, y, n;
    logic [7:0] a, b;
    logic [9:0] r;
    bit         ok;
    int         acc, lat;
    exp_t       it;
    x = ins[11:8]; y = ins[7:4]; n = ins[3:0];
    ok = (ins[15:12] == 4'h8) && (n <= 4'h7 || n == 4'hE);
    a = m[x]; b = m[y];
    check1("ready_before_accept", {7'b0, instr_ready}, 8'h01);
    instr_valid = 1'b1; instr = ins;
    ext_we = ext; ext_addr = ea; ext_wdata = ed;
    @(posedge clk); #1;
    acc = cyc;
    instr_valid = 1'b0; ext_we = 1'b0; instr = 16'($urandom);
    if (ext) m[ea] = ed;
    if (ok) begin
      r = ovr_en ? {ovr_vf, ovr_flag, ovr_out} : alu_ref(n, a, b);
      m[x] = r[7:0];
      if (r[9]) m[15] = {7'b0, r[8]};
      lat = r[9] ? 3 : 2;
      it.is_done = 1'b1; it.cyc = acc + lat; it.regs = snap();
      sb.push_back(it);
      check1("ready_while_busy", {7'b0, instr_ready}, 8'h00);
      for (int k = 0; k < lat; k++) begin
        ext_we = junk ? 1'($urandom) : 1'b0;
        ext_addr = 4'($urandom); ext_wdata = 8'($urandom);
        @(posedge clk); #1;
      end
      ext_we = 1'b0;
    end else begin
      it.is_done = 1'b0; it.cyc = acc; it.regs = snap();
      sb.push_back(it);
      check1("ready_after_illegal", {7'b0, instr_ready}, 8'h01);
    end
  endtask

  // Monitor: every done/illegal pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done === 1'b1 || illegal === 1'b1)) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pulse: done=%0b illegal=%0b at cycle %0d, expected no pulse", done, illegal, cyc);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (done !== e.is_done || illegal !== !e.is_done || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL pulse_timing: done=%0b illegal=%0b at cycle %0d, expected done=%0b at cycle %0d",
                   done, illegal, cyc, e.is_done, e.cyc);
        end
        for (int i = 0; i < 16; i++) begin
          rd_addr = 4'(i);
          #1;
          n_cmp++;
          if (rd_data !== e.regs[i*8 +: 8]) begin
            n_bad++;
            $display("FAIL reg_V%0h: got %h, expected %h (cycle %0d)", i, rd_data, e.regs[i*8 +: 8], cyc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d responses outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  nlist [9];
    logic [3:0]  bad_n [7];
    logic [15:0] ins;
    int          t;
    nlist = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
    bad_n = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    rst_n = 1'b0; instr_valid = 1'b1; instr = 16'h8124;
    ext_we = 1'b1; ext_addr = 4'h3; ext_wdata = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    instr_valid = 1'b0; ext_we = 1'b0;
    check1("reset_ready", {7'b0, instr_ready}, 8'h01);
    check1("reset_done", {7'b0, done}, 8'h00);
    check1("reset_illegal", {7'b0, illegal}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero file after reset; result of 8010 is 0.
    do_instr(16'h8010, 1'b0, 4'h0, 8'h00, 1'b0);

    // Add with carry.
    ext_write(4'h1, 8'hF0); ext_write(4'h2, 8'h20);
    do_instr(16'h8124, 1'b0, 4'h0, 8'h00, 1'b1);
    // Subtract with borrow.
    ext_write(4'h3, 8'h05); ext_write(4'h4, 8'h07);
    do_instr(16'h8345, 1'b0, 4'h0, 8'h00, 1'b1);
    // X=F: flag write wins over result (forced ALU result 0, flag 0).
    ext_write(4'hF, 8'hFF); ext_write(4'h1, 8'h01);
    ovr_en = 1'b1; ovr_out = 8'h00; ovr_flag = 1'b0; ovr_vf = 1'b1;
    do_instr(16'h8F14, 1'b0, 4'h0, 8'h00, 1'b0);
    ovr_en = 1'b0;
    ext_write(4'hF, 8'hFF); ext_write(4'h1, 8'hFF);
    do_instr(16'h8F14, 1'b0, 4'h0, 8'h00, 1'b0);
    // AND without VF update.
    ext_write(4'h1, 8'h3C); ext_write(4'h2, 8'h0F); ext_write(4'hF, 8'hAA);
    do_instr(16'h8122, 1'b0, 4'h0, 8'h00, 1'b1);
    // Illegal opcodes.
    do_instr(16'h8128, 1'b0, 4'h0, 8'h00, 1'b0);
    do_instr(16'h9120, 1'b0, 4'h0, 8'h00, 1'b0);
    // Coincident external write to VX: operands see pre-write value.
    do_instr(16'h8124, 1'b1, 4'h1, 8'h99, 1'b0);

    // Reset while in WB_VX aborts the instruction.
    ext_write(4'h5, 8'h77);
    instr_valid = 1'b1; instr = 16'h8504;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    ext_we = 1'b1; ext_addr = 4'h6; ext_wdata = 8'h55;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; ext_we = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    check1("abort_ready", {7'b0, instr_ready}, 8'h01);
    check1("abort_done", {7'b0, done}, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    do_instr(16'h8010, 1'b0, 4'h0, 8'h00, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      t = $urandom_range(0, 9);
      if (t < 2) ext_write(4'($urandom), 8'($urandom));
      if (t == 9) begin
        if ($urandom_range(0, 1) == 0)
          ins = {4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), nlist[$urandom_range(0, 8)]};
        else
          ins = {4'h8, 4'($urandom), 4'($urandom), bad_n[$urandom_range(0, 6)]};
      end else begin
        ins = {4'h8, 4'($urandom), 4'($urandom), nlist[$urandom_range(0, 8)]};
      end
      do_instr(ins, ($urandom_range(0, 2) == 0), 4'($urandom), 8'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_responses: %0d outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
